dsp_pipe_reg: RTL and testbench
===============================

Name: dsp_pipe_reg

Overview:
- Registered-path source for the DSP48A1 slice model: a parameterised chain of data/valid register stages producing the in_REG operand that the registered/combinational selection consumes.
- Adds clock enable, synchronous flush, a stage tap and an occupancy counter, so the A/B/C/D/M/P register banks and their verification share one tracked pipeline primitive.

Parameters:
- WIDTH, 18, data width in bits (1..48).
- DEPTH, 2, number of register stages (1..4); sets data latency.
- RST_VAL, 0, value loaded into every data stage on reset or flush (WIDTH bits).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- CE  input  1  clock enable; when 0, all stages, valids and counter hold.
- FLUSH  input  1  synchronous clear of data, valids and counter (acts only when CE=1).
- din  input  WIDTH  data into stage 0.
- din_vld  input  1  qualifies din.
- tap_sel  input  2  selects stage for tap output (clamped to DEPTH-1).
- dout  output  WIDTH  last-stage data (registered path).
- dout_vld  output  1  last-stage valid.
- tap  output  WIDTH  data of stage min(tap_sel, DEPTH-1), combinational read of registers.
- tap_vld  output  1  valid of the tapped stage.
- occ  output  3  count of valid stages, 0..DEPTH.
- full  output  1  occ == DEPTH.

Behaviour:
- Reset (RST=1, asynchronous, overrides everything):
  - every data stage = RST_VAL, every valid = 0, occ = 0.
  - Resulting outputs: dout = RST_VAL, dout_vld = 0, tap = RST_VAL, tap_vld = 0, full = 0.
  - Deassertion takes effect at the next CLK edge.
- Shift on each rising CLK edge with CE=1 and FLUSH=0:
  - stage0 <= din, vld0 <= din_vld.
  - stage[i] <= stage[i-1], vld[i] <= vld[i-1] for i = 1..DEPTH-1.
  - Data shifts whether or not valid; valid only marks it.
- Latency: din accepted at edge k appears on dout after edge k+DEPTH-1, i.e. DEPTH CE-enabled edges after it is presented.
- CE=0: complete freeze of data, valids and occ. FLUSH and din are ignored.
- FLUSH=1 with CE=1: all data = RST_VAL, valids = 0, occ = 0. Same-cycle din is discarded. FLUSH has priority over shift.
- occ:
  - next occ = occ + din_vld - vld[DEPTH-1] on a shift edge.
  - Saturates within 0..DEPTH by construction; an assertion checks occ == popcount(valids) every cycle.
- full: combinational from occ.
- tap_sel ≥ DEPTH reads stage DEPTH-1 (no X, no wrap).
- DEPTH=1: single stage; occ is 0 or 1; tap equals dout for all tap_sel.
- Simultaneous valid-in and valid-out on one edge leaves occ unchanged.
- No backpressure: a valid reaching the last stage is dropped on the next shift, and downstream must sample it in that cycle.
- RST mid-stream discards all in-flight data with no residual valid.

Test Plan:
- Reset: assert RST asynchronously between edges with RST_VAL=0x15 and DEPTH=2 → dout=0x15 and dout_vld=0 immediately; occ=0, full=0 after release.
- Latency: DEPTH=3, CE=1, drive din=0x00001..0x00005 with din_vld=1 on consecutive edges → dout=0x00001 with dout_vld=1 after the 3rd edge, then sequential values. occ steps 1,2,3 and holds 3; full=1 from the 3rd edge.
- Enable freeze: DEPTH=2, load 0xAAAA then 0x5555, drop CE for 4 cycles while din changes → dout and occ unchanged; on CE=1 shifting resumes with no lost or duplicated word.
- Flush priority: DEPTH=4, pipeline full, assert FLUSH with CE=1 and din_vld=1 on one edge → all valids 0, occ=0, data=RST_VAL. Same FLUSH with CE=0 → no effect.
- Tap and bubbles: DEPTH=4, valid pattern 1,0,1,1 with data 0x11,0x22,0x33,0x44:
  - tap_sel=1 → tap=0x33, tap_vld=1.
  - tap_sel=2 → tap=0x22, tap_vld=0.
  - occ=3.
  - On DEPTH=2, tap_sel=3 → returns stage1.
- Reset mid-stream: DEPTH=3 with 2 words in flight, pulse RST for half a cycle → dout_vld never asserts for those words; the next accepted word has latency 3.

Source files
------------

// File: rtl/dsp_pipe_reg.sv
// ---------------------------------------------------------------------------
// dsp_pipe_reg
//
// Purpose:
//   Tracked register pipeline used as the registered-path operand source of
//   the DSP48A1 slice model. A chain of DEPTH data/valid stages with clock
//   enable, synchronous flush, a stage tap for debug/visibility, and an
//   occupancy counter of valid stages. The A/B/C/D/M/P register banks are
//   all built from this one primitive.
//
// Parameters:
//   WIDTH   - data width in bits (1..48)
//   DEPTH   - number of register stages (1..4); sets data latency
//   RST_VAL - value loaded into every data stage on reset or flush
//
// Ports:
//   CLK      in   1      rising-edge clock
//   RST      in   1      asynchronous active-high reset
//   CE       in   1      clock enable; 0 freezes everything
//   FLUSH    in   1      synchronous clear of data/valids/occ (only when CE=1)
//   din      in   WIDTH  data into stage 0
//   din_vld  in   1      qualifies din
//   tap_sel  in   2      tap stage select, clamped to DEPTH-1
//   dout     out  WIDTH  last-stage data
//   dout_vld out  1      last-stage valid
//   tap      out  WIDTH  data of stage min(tap_sel, DEPTH-1)
//   tap_vld  out  1      valid of the tapped stage
//   occ      out  3      number of valid stages, 0..DEPTH
//   full     out  1      occ == DEPTH
// ---------------------------------------------------------------------------
module dsp_pipe_reg #(
    parameter int               WIDTH   = 18,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] din,
    input  logic             din_vld,
    input  logic [1:0]       tap_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [WIDTH-1:0] tap,
    output logic             tap_vld,
    output logic [2:0]       occ,
    output logic             full
);

    // Stage storage: index 0 is the input stage, DEPTH-1 drives dout.
    logic [WIDTH-1:0] stageData_q [DEPTH];
    logic [WIDTH-1:0] stageData_d [DEPTH];
    logic [DEPTH-1:0] stageVld_q;
    logic [DEPTH-1:0] stageVld_d;
    logic [2:0]       occ_q;
    logic [2:0]       occ_d;

    // Tap index after clamping; held as int so the stage loop below
    // compares without width mismatches for any DEPTH.
    int               tapIdx;

    // Independent population count of the valid bits, used only to
    // cross-check the incrementally maintained occupancy counter.
    logic [2:0]       vldCount;

    // Next-state logic. With CE low everything holds; FLUSH wins over a
    // shift and discards the word presented in the same cycle. Data moves
    // regardless of its valid bit so bubbles travel through like words.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stageData_d[i] = stageData_q[i];
        end
        stageVld_d = stageVld_q;
        occ_d      = occ_q;

        if (CE) begin
            if (FLUSH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stageData_d[i] = RST_VAL;
                end
                stageVld_d = '0;
                occ_d      = '0;
            end else begin
                stageData_d[0] = din;
                stageVld_d[0]  = din_vld;
                for (int i = 1; i < DEPTH; i++) begin
                    stageData_d[i] = stageData_q[i-1];
                    stageVld_d[i]  = stageVld_q[i-1];
                end
                // A valid entering and one leaving on the same edge cancel,
                // so the count can never leave 0..DEPTH.
                occ_d = occ_q + 3'(din_vld) - 3'(stageVld_q[DEPTH-1]);
            end
        end
    end

    // State registers with asynchronous reset to the idle, empty pipeline.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= RST_VAL;
            end
            stageVld_q <= '0;
            occ_q      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stageData_q[i] <= stageData_d[i];
            end
            stageVld_q <= stageVld_d;
            occ_q      <= occ_d;
        end
    end

    // Clamp the tap select so out-of-range selects read the last stage
    // instead of wrapping or producing X.
    always_comb begin
        if (int'(tap_sel) >= DEPTH) begin
            tapIdx = DEPTH - 1;
        end else begin
            tapIdx = int'(tap_sel);
        end
    end

    // Tap read as a loop mux over the stages, avoiding a variable index
    // whose width would not match small DEPTH values.
    always_comb begin
        tap     = RST_VAL;
        tap_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == tapIdx) begin
                tap     = stageData_q[i];
                tap_vld = stageVld_q[i];
            end
        end
    end

    // Population count of the valid bits.
    always_comb begin
        vldCount = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vldCount = vldCount + 3'(stageVld_q[i]);
        end
    end

    // The counter must always agree with the actual number of valid stages.
    occMatchesValids: assert property (@(posedge CLK) disable iff (RST) occ_q == vldCount);

    assign dout     = stageData_q[DEPTH-1];
    assign dout_vld = stageVld_q[DEPTH-1];
    assign occ      = occ_q;
    assign full     = (occ_q == 3'(DEPTH));

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_dsp_pipe_reg
//
// Directed self-checking bench for dsp_pipe_reg. Four instances with
// DEPTH 1..4 share one set of inputs; each scenario resets all of them and
// then checks the instance whose depth the scenario is about.
// ---------------------------------------------------------------------------
module tb_dsp_pipe_reg;

    localparam int W = 18;

    logic         CLK;
    logic         RST;
    logic         CE;
    logic         FLUSH;
    logic [W-1:0] din;
    logic         din_vld;
    logic [1:0]   tap_sel;

    logic [W-1:0] dout1, tap1, dout2, tap2, dout3, tap3, dout4, tap4;
    logic         doutVld1, tapVld1, full1, doutVld2, tapVld2, full2;
    logic         doutVld3, tapVld3, full3, doutVld4, tapVld4, full4;
    logic [2:0]   occ1, occ2, occ3, occ4;

    int checkCount;
    int failCount;

    dsp_pipe_reg #(.WIDTH(W), .DEPTH(1), .RST_VAL(18'h0)) u1 (
        .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .din(din), .din_vld(din_vld),
        .tap_sel(tap_sel), .dout(dout1), .dout_vld(doutVld1), .tap(tap1),
        .tap_vld(tapVld1), .occ(occ1), .full(full1));

    dsp_pipe_reg #(.WIDTH(W), .DEPTH(2), .RST_VAL(18'h15)) u2 (
        .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .din(din), .din_vld(din_vld),
        .tap_sel(tap_sel), .dout(dout2), .dout_vld(doutVld2), .tap(tap2),
        .tap_vld(tapVld2), .occ(occ2), .full(full2));

    dsp_pipe_reg #(.WIDTH(W), .DEPTH(3), .RST_VAL(18'h0)) u3 (
        .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .din(din), .din_vld(din_vld),
        .tap_sel(tap_sel), .dout(dout3), .dout_vld(doutVld3), .tap(tap3),
        .tap_vld(tapVld3), .occ(occ3), .full(full3));

    dsp_pipe_reg #(.WIDTH(W), .DEPTH(4), .RST_VAL(18'h3)) u4 (
        .CLK(CLK), .RST(RST), .CE(CE), .FLUSH(FLUSH), .din(din), .din_vld(din_vld),
        .tap_sel(tap_sel), .dout(dout4), .dout_vld(doutVld4), .tap(tap4),
        .tap_vld(tapVld4), .occ(occ4), .full(full4));

    // Free-running 10-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Counts one comparison and reports it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [47:0] observed,
                               input logic [47:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, then waits for the edge and settles 1
    // unit past it so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic ce, input logic flush,
                                 input logic [W-1:0] d, input logic v);
        CE      = ce;
        FLUSH   = flush;
        din     = d;
        din_vld = v;
        @(posedge CLK);
        #1;
    endtask

    // Synchronous-looking reset pulse spanning one edge.
    task automatic applyReset();
        RST     = 1'b1;
        CE      = 1'b0;
        FLUSH   = 1'b0;
        din_vld = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        RST        = 1'b1;
        CE         = 1'b0;
        FLUSH      = 1'b0;
        din        = '0;
        din_vld    = 1'b0;
        tap_sel    = 2'd0;
        @(posedge CLK);
        @(posedge CLK);
        #1;

        // Reset state of the whole family.
        checkOutput("rst_dout2", dout2, 18'h15);
        checkOutput("rst_dvld2", doutVld2, 1'b0);
        checkOutput("rst_tap2", tap2, 18'h15);
        checkOutput("rst_occ2", occ2, 3'd0);
        checkOutput("rst_full2", full2, 1'b0);
        checkOutput("rst_dout4", dout4, 18'h3);

        // Asynchronous reset mid-cycle on DEPTH=2.
        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 18'h7, 1'b1);
        applyStimulus(1'b1, 1'b0, 18'h7, 1'b1);
        checkOutput("pre_rst_dout2", dout2, 18'h7);
        checkOutput("pre_rst_full2", full2, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async_rst_dout2", dout2, 18'h15);
        checkOutput("async_rst_dvld2", doutVld2, 1'b0);
        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("post_rst_occ2", occ2, 3'd0);
        checkOutput("post_rst_full2", full2, 1'b0);

        // Latency on DEPTH=3: words 1..5 back to back.
        applyReset();
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 1'b0, W'(k), 1'b1);
            checkOutput($sformatf("lat_occ3_%0d", k), occ3, (k >= 3) ? 3 : k);
            checkOutput($sformatf("lat_dvld3_%0d", k), doutVld3, (k >= 3) ? 1 : 0);
            checkOutput($sformatf("lat_full3_%0d", k), full3, (k >= 3) ? 1 : 0);
            if (k >= 3) begin
                checkOutput($sformatf("lat_dout3_%0d", k), dout3, k - 2);
            end
        end

        // Enable freeze on DEPTH=2.
        applyReset();
        applyStimulus(1'b1, 1'b0, 18'hAAAA, 1'b1);
        applyStimulus(1'b1, 1'b0, 18'h5555, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 1'b0, W'(k * 18'h1111), 1'b1);
            checkOutput($sformatf("frz_dout2_%0d", k), dout2, 18'hAAAA);
            checkOutput($sformatf("frz_occ2_%0d", k), occ2, 3'd2);
        end
        applyStimulus(1'b1, 1'b0, 18'h1234, 1'b1);
        checkOutput("resume_dout2_a", dout2, 18'h5555);
        checkOutput("resume_occ2_a", occ2, 3'd2);
        applyStimulus(1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("resume_dout2_b", dout2, 18'h1234);
        checkOutput("resume_occ2_b", occ2, 3'd1);

        // Flush priority on DEPTH=4.
        applyReset();
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, W'(k), 1'b1);
        end
        checkOutput("fill_full4", full4, 1'b1);
        applyStimulus(1'b0, 1'b1, 18'h99, 1'b1);
        checkOutput("flush_ce0_occ4", occ4, 3'd4);
        checkOutput("flush_ce0_dout4", dout4, 18'h1);
        applyStimulus(1'b1, 1'b1, 18'h99, 1'b1);
        tap_sel = 2'd0;
        #1;
        checkOutput("flush_occ4", occ4, 3'd0);
        checkOutput("flush_dout4", dout4, 18'h3);
        checkOutput("flush_dvld4", doutVld4, 1'b0);
        checkOutput("flush_full4", full4, 1'b0);
        checkOutput("flush_tap4_s0", tap4, 18'h3);
        checkOutput("flush_tapvld4_s0", tapVld4, 1'b0);

        // Tap and bubbles: entries 11,22,33,44 with valids 1,0,1,1.
        applyReset();
        applyStimulus(1'b1, 1'b0, 18'h11, 1'b1);
        applyStimulus(1'b1, 1'b0, 18'h22, 1'b0);
        applyStimulus(1'b1, 1'b0, 18'h33, 1'b1);
        applyStimulus(1'b1, 1'b0, 18'h44, 1'b1);
        CE = 1'b0;
        checkOutput("bub_occ4", occ4, 3'd3);
        checkOutput("bub_full4", full4, 1'b0);
        checkOutput("bub_dout4", dout4, 18'h11);
        tap_sel = 2'd0; #1;
        checkOutput("tap4_s0", tap4, 18'h44);
        checkOutput("tap1_s0", tap1, 18'h44);
        tap_sel = 2'd1; #1;
        checkOutput("tap4_s1", tap4, 18'h33);
        checkOutput("tapvld4_s1", tapVld4, 1'b1);
        tap_sel = 2'd2; #1;
        checkOutput("tap4_s2", tap4, 18'h22);
        checkOutput("tapvld4_s2", tapVld4, 1'b0);
        tap_sel = 2'd3; #1;
        checkOutput("tap4_s3", tap4, 18'h11);
        checkOutput("tap2_s3", tap2, 18'h33);
        checkOutput("tapvld2_s3", tapVld2, 1'b1);
        checkOutput("tap1_s3", tap1, 18'h44);
        checkOutput("occ1", occ1, 3'd1);
        // Valid in and valid out on one edge leaves occ unchanged.
        applyStimulus(1'b1, 1'b0, 18'h55, 1'b1);
        checkOutput("inout_occ4", occ4, 3'd3);
        checkOutput("inout_dout4", dout4, 18'h22);
        checkOutput("inout_occ1", occ1, 3'd1);
        checkOutput("inout_dout1", dout1, 18'h55);

        // Reset mid-stream on DEPTH=3: two words in flight, half-cycle pulse.
        applyReset();
        applyStimulus(1'b1, 1'b0, 18'hA1, 1'b1);
        applyStimulus(1'b1, 1'b0, 18'hA2, 1'b1);
        din_vld = 1'b0;
        RST = 1'b1;
        #5;
        RST = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 1'b0, 18'h0, 1'b0);
            checkOutput($sformatf("midrst_dvld3_%0d", k), doutVld3, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 18'hB7, 1'b1);
        checkOutput("relat_dvld3_1", doutVld3, 1'b0);
        applyStimulus(1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("relat_dvld3_2", doutVld3, 1'b0);
        applyStimulus(1'b1, 1'b0, 18'h0, 1'b0);
        checkOutput("relat_dvld3_3", doutVld3, 1'b1);
        checkOutput("relat_dout3_3", dout3, 18'hB7);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
